// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1101 serial sequence detector.
// Optional feature macro: SEQ_DETECTOR_COUNT_EN (enables the match counter).
package seq_det_pkg;

   // Detector progress through the pattern, named by the bits seen so far.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S1   = 2'd1,
      S11  = 2'd2,
      S110 = 2'd3
   } state_t;

   // Target pattern, oldest bit in the MSB.
   localparam logic [3:0] PATTERN = 4'b1101;

   // Width of the saturating match counter.
   localparam int unsigned COUNT_W = 8;

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
// Only instantiated when SEQ_DETECTOR_COUNT_EN is defined.
module sat_counter
   import seq_det_pkg::*;
#(
   parameter int unsigned W = COUNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Reset beats clear, clear beats increment; the count holds at all-ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/seq_detector.sv
// Serial detector for the pattern 1101 (oldest bit first) with a registered
// one-cycle match pulse and an optional saturating match counter.
// Optional feature macro: SEQ_DETECTOR_COUNT_EN. When undefined, match_count
// is tied to zero, no counter flops exist and clr is ignored.
module seq_detector
   import seq_det_pkg::*;
#(
   parameter int OVERLAP = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               x,
   input  logic               x_valid,
   input  logic               clr,
   output logic               y,
   output logic [COUNT_W-1:0] match_count
);

   state_t state;
   state_t state_next;
   logic   hit;

   // Next-state and match decode; nothing advances on edges without x_valid.
   always_comb begin
      state_next = state;
      hit        = 1'b0;
      if (x_valid) begin
         unique case (state)
            IDLE: state_next = (x == PATTERN[3]) ? S1 : IDLE;
            S1:   state_next = (x == PATTERN[2]) ? S11 : IDLE;
            // A third 1 still leaves the last two bits as "11".
            S11:  state_next = (x == PATTERN[1]) ? S110 : S11;
            S110: begin
               if (x == PATTERN[0]) begin
                  hit = 1'b1;
                  // The completing 1 can start the next pattern when overlapping.
                  state_next = (OVERLAP != 0) ? S1 : IDLE;
               end else begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State register and registered match pulse; clr has no effect here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         y     <= 1'b0;
      end else begin
         state <= state_next;
         y     <= hit;
      end
   end

`ifdef SEQ_DETECTOR_COUNT_EN
   sat_counter #(
      .W(COUNT_W)
   ) u_sat_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (hit),
      .clr   (clr),
      .count (match_count)
   );
`else
   assign match_count = '0;

   // clr has no function without the counter.
   logic unused_clr;
   assign unused_clr = clr;
`endif

endmodule : seq_detector

// File: tb/tb_seq_detector.sv
// Directed self-checking bench for seq_detector. Runs an OVERLAP=1 and an
// OVERLAP=0 instance side by side on the same stimulus. Expected counts
// follow SEQ_DETECTOR_COUNT_EN (zero when the macro is undefined).
module tb_seq_detector;
   import seq_det_pkg::*;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               x = 1'b0;
   logic               x_valid = 1'b0;
   logic               clr = 1'b0;
   logic               y1;
   logic               y0;
   logic [COUNT_W-1:0] cnt1;
   logic [COUNT_W-1:0] cnt0;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   seq_detector #(.OVERLAP(1)) dut_ov (
      .clk         (clk),
      .reset       (reset),
      .x           (x),
      .x_valid     (x_valid),
      .clr         (clr),
      .y           (y1),
      .match_count (cnt1)
   );

   seq_detector #(.OVERLAP(0)) dut_no (
      .clk         (clk),
      .reset       (reset),
      .x           (x),
      .x_valid     (x_valid),
      .clr         (clr),
      .y           (y0),
      .match_count (cnt0)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Expected counter value after n matches, given the build configuration.
   function automatic logic [31:0] exp_cnt(input int unsigned n);
`ifdef SEQ_DETECTOR_COUNT_EN
      return (n > 255) ? 32'd255 : 32'(n);
`else
      return 32'd0;
`endif
   endfunction

   // Drive one cycle at the falling edge; return just after the rising edge.
   task automatic step(input logic xi, input logic vi, input logic rsti, input logic clri);
      @(negedge clk);
      x       = xi;
      x_valid = vi;
      reset   = rsti;
      clr     = clri;
      @(posedge clk);
      #1;
   endtask

   // One valid bit, checking both pulse outputs.
   task automatic vbit(input string tag, input logic b, input logic e1, input logic e0);
      step(b, 1'b1, 1'b1, 1'b0);
      check_eq({tag, ".y_ov"}, 32'(y1), 32'(e1));
      check_eq({tag, ".y_no"}, 32'(y0), 32'(e0));
   endtask

   task automatic counts(input string tag, input int unsigned n1, input int unsigned n0);
      check_eq({tag, ".cnt_ov"}, 32'(cnt1), exp_cnt(n1));
      check_eq({tag, ".cnt_no"}, 32'(cnt0), exp_cnt(n0));
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset held with x=1, x_valid=1: must not advance the FSM.
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("rst.y_ov", 32'(y1), 32'd0);
      check_eq("rst.y_no", 32'(y0), 32'd0);
      counts("rst", 0, 0);
      // If reset had let state reach S11, "0,1" would complete a match.
      vbit("rst.b0", 1'b0, 1'b0, 1'b0);
      vbit("rst.b1", 1'b1, 1'b0, 1'b0);
      counts("rst.post", 0, 0);

      // Basic 1101.
      do_reset();
      vbit("basic.1", 1'b1, 1'b0, 1'b0);
      vbit("basic.2", 1'b1, 1'b0, 1'b0);
      vbit("basic.3", 1'b0, 1'b0, 1'b0);
      vbit("basic.4", 1'b1, 1'b1, 1'b1);
      counts("basic", 1, 1);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_eq("basic.after.y_ov", 32'(y1), 32'd0);
      check_eq("basic.after.y_no", 32'(y0), 32'd0);
      counts("basic.after", 1, 1);

      // Overlap 1101101.
      do_reset();
      vbit("ovl.1", 1'b1, 1'b0, 1'b0);
      vbit("ovl.2", 1'b1, 1'b0, 1'b0);
      vbit("ovl.3", 1'b0, 1'b0, 1'b0);
      vbit("ovl.4", 1'b1, 1'b1, 1'b1);
      vbit("ovl.5", 1'b1, 1'b0, 1'b0);
      vbit("ovl.6", 1'b0, 1'b0, 1'b0);
      vbit("ovl.7", 1'b1, 1'b1, 1'b0);
      counts("ovl", 2, 1);

      // Self-loop in S11 and invalid gaps holding state S110 (x=1 ignored).
      do_reset();
      vbit("gap.1", 1'b1, 1'b0, 1'b0);
      vbit("gap.2", 1'b1, 1'b0, 1'b0);
      vbit("gap.3", 1'b1, 1'b0, 1'b0);
      vbit("gap.4", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         check_eq("gap.idle.y_ov", 32'(y1), 32'd0);
         check_eq("gap.idle.y_no", 32'(y0), 32'd0);
      end
      vbit("gap.5", 1'b1, 1'b1, 1'b1);
      counts("gap", 1, 1);

      // Reset mid-pattern discards the partial match.
      do_reset();
      vbit("mid.1", 1'b1, 1'b0, 1'b0);
      vbit("mid.2", 1'b1, 1'b0, 1'b0);
      vbit("mid.3", 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("mid.rst.y_ov", 32'(y1), 32'd0);
      vbit("mid.4", 1'b1, 1'b0, 1'b0);
      counts("mid", 0, 0);

      // Saturation: 1101 then 299 x "101". OVERLAP=1 matches on every
      // triple (300 total); OVERLAP=0 matches on every second triple (150).
      do_reset();
      vbit("sat.1", 1'b1, 1'b0, 1'b0);
      vbit("sat.2", 1'b1, 1'b0, 1'b0);
      vbit("sat.3", 1'b0, 1'b0, 1'b0);
      vbit("sat.4", 1'b1, 1'b1, 1'b1);
      for (int t = 1; t <= 299; t++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0);
         step(1'b0, 1'b1, 1'b1, 1'b0);
         step(1'b1, 1'b1, 1'b1, 1'b0);
         if (t == 254) counts("sat.255", 255, 128);
      end
      check_eq("sat.last.y_ov", 32'(y1), 32'd1);
      check_eq("sat.last.y_no", 32'(y0), 32'd0);
      counts("sat", 300, 150);

      // Both instances now sit in S1. clr on a match edge: clr wins, y pulses.
      vbit("clr.1", 1'b1, 1'b0, 1'b0);
      vbit("clr.2", 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check_eq("clr.hit.y_ov", 32'(y1), 32'd1);
      check_eq("clr.hit.y_no", 32'(y0), 32'd1);
      counts("clr.hit", 0, 0);

      // clr mid-pattern must not disturb the FSM.
      vbit("clr.3", 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("clr.mid.y_ov", 32'(y1), 32'd0);
      vbit("clr.4", 1'b1, 1'b1, 1'b0);
      counts("clr.end", 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_seq_detector
